mole: RTL and testbench
=======================

# mole

Mole spawner and lifetime tracker for the whack-a-mole game core. After a `start` pulse it periodically places moles into five holes, ages each mole against a programmable lifetime, and removes moles on expiry or when the player hits them via `kill_list`. It sits between the input/debounce logic, which produces `kill_list`, and the display and scoring logic, which consume `moles`.

## Interface
- No parameters. Hole count (5) and field width (4) are package constants.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-high reset. The name is kept for codebase consistency; the reset asserts when the signal is 1.
- `start` in 1: a high level at a clock edge starts the game.
- `life_span` in 32: mole lifetime in clk cycles. Sampled when a mole spawns.
- `gen_interval` in 32: spawn period in clk cycles. Read live.
- `kill_list` in 5: bit i high means hit hole i. Level-sensitive.
- `moles` out 20: hole i is reported on `moles[4i+3:4i]`. A field of 0 means the hole is empty; a nonzero field is the mole value.

## Operation
- States:
  - IDLE: the state after reset. No spawning, all holes empty.
  - RUN: entered when `start` is 1 in IDLE. The block stays in RUN until reset.
  - `start` is ignored while in RUN.
- Spawn counter `gen_cnt` (32 bit):
  - Cleared on entry to RUN.
  - On each RUN edge: if `gen_cnt >= max(gen_interval,1)-1`, spawn and clear `gen_cnt`; otherwise increment it.
- Spawn target selection:
  - Consider only holes that are empty at the current cycle.
  - Search cyclically from a start index and take the first empty hole.
  - If all 5 holes are occupied, skip the spawn. `gen_cnt` still wraps.
- On spawn:
  - The hole's life counter loads `max(life_span,1)`.
  - The hole's field is set to the mole value.
- Occupied holes, each edge:
  - If `kill_list[i]` is 1: the hole is cleared.
  - Else if the life counter is 1: the hole is cleared (expiry).
  - Else: the life counter decrements.
- Kill on an empty hole has no effect.
- A hole cleared this cycle can be chosen for a spawn no earlier than the next cycle.
- Kill and expiry in the same cycle: the result is a single clear.
- Reset at any time: state returns to IDLE, all counters clear, `moles` = 0 on the next edge.

## Timing
- Reset value: `moles` = 20'h0, state IDLE.
- Start: `start` sampled high at edge E0 puts the block in RUN from E0.
  - The first spawn is visible after edge E0 + gen_interval.
  - Later spawns are visible every gen_interval cycles.
- A mole stays visible for exactly `life_span` cycles unless it is killed.
- Kill latency: 1 cycle. The field reads 0 after the first edge at which `kill_list[i]` is seen high.
- A change to `gen_interval` takes effect at the next comparison. If `gen_cnt` is already at or above the new value, the block spawns immediately.

## Configuration
- `MOLE_RANDOM_EN` defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to the seed) advances every cycle.
  - Search start index = `lfsr % 5`.
  - Mole value = `(lfsr[7:4] % 9) + 1`, range 1..9.
- `MOLE_RANDOM_EN` undefined:
  - Round-robin pointer, reset to 0. The search starts at the pointer.
  - After a successful spawn, pointer = (chosen hole + 1) mod 5.
  - Mole value is always 4'd1.

## Structure
- Package `mole_pkg` holds:
  - `NUM_HOLES` = 5 and `FIELD_W` = 4.
  - The state enum {IDLE, RUN}.
  - The LFSR seed and tap constants.
- One natural sub-module: `mole_hole`. It is instantiated ×5 and holds one life counter and one field, with spawn, kill and expire logic.

## Test plan
Run with `MOLE_RANDOM_EN` undefined.
1. Reset, then idle for 10 cycles with no `start` → `moles` = 0 throughout.
2. `start` pulse with gen_interval=50, life_span=100 → hole0 = 1 after 50 cycles, hole1 = 1 at 100, hole0 clears at 150 as hole2 spawns.
3. gen_interval=30, life_span=150 → 5 holes full after 5 spawns. The 6th spawn is skipped. Refill occurs only after an expiry.
4. `kill_list` = 5'b01011 for 1 cycle with holes 0, 1, 3 occupied → those fields are 0 one cycle later. Holes 2 and 4 are unchanged.
5. Kill on an empty hole → no change. A kill coinciding with expiry → a single clear with no spurious respawn in the same cycle.
6. Reset asserted mid-RUN → `moles` = 0 next edge and the block is in IDLE. A new `start` is required before any further spawns.

Source files
------------

// File: rtl/mole_pkg.sv
// mole_pkg: shared constants and types for the mole spawner (MOLE_RANDOM_EN selects LFSR placement).
package mole_pkg;
    localparam int NUM_HOLES = 5;
    localparam int FIELD_W = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/mole_hole.sv
// mole_hole: one hole's mole field and life counter with spawn, kill and expiry.
module mole_hole
    import mole_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spawn,
    input  logic               kill,
    input  logic [FIELD_W-1:0] value,
    input  logic [31:0]        life,
    output logic [FIELD_W-1:0] field
);
    logic [31:0] cnt;
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt   <= '0;
            field <= '0;
        end else if (spawn) begin
            cnt   <= life;
            field <= value;
        end else if (field != '0) begin
            if (kill || cnt == 32'd1) begin
                cnt   <= '0;
                field <= '0;
            end else begin
                cnt <= cnt - 32'd1;
            end
        end
    end
endmodule

// File: rtl/mole.sv
// mole: periodic mole spawner over five holes; MOLE_RANDOM_EN swaps round-robin placement for an LFSR.
module mole
    import mole_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [31:0]                  life_span,
    input  logic [31:0]                  gen_interval,
    input  logic [NUM_HOLES-1:0]         kill_list,
    output logic [NUM_HOLES*FIELD_W-1:0] moles
);
    state_t               state, state_next;
    logic                 run, tick, found;
    logic [31:0]          gen_cnt, gen_max, life;
    logic [2:0]           first, sel;
    logic [3:0]           sum;
    logic [FIELD_W-1:0]   value;
    logic [NUM_HOLES-1:0] empty, spawn_vec;

    always_ff @(posedge clk) begin
        state <= rst_n ? IDLE : state_next;
    end

    always_comb begin
        state_next = (state == IDLE && start) ? RUN : state;
    end

    always_comb begin
        run = state == RUN;
    end

    always_ff @(posedge clk) begin
        if (rst_n || !run) gen_cnt <= '0;
        else gen_cnt <= tick ? '0 : gen_cnt + 32'd1;
    end

    assign gen_max = (gen_interval == '0) ? '0 : gen_interval - 32'd1;
    assign tick    = run && gen_cnt >= gen_max;
    assign life    = (life_span == '0) ? 32'd1 : life_span;

    // Only holes empty at the current cycle qualify, so a hole clearing now cannot be refilled now.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        for (int k = 0; k < NUM_HOLES; k++) begin
            sum = {1'b0, first} + 4'(k);
            sum = (sum >= 4'(NUM_HOLES)) ? sum - 4'(NUM_HOLES) : sum;
            if (!found && empty[sum[2:0]]) begin
                found = 1'b1;
                sel   = sum[2:0];
            end
        end
    end

    assign spawn_vec = (tick && found) ? NUM_HOLES'(1) << sel : '0;

`ifdef MOLE_RANDOM_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        lfsr <= rst_n ? LFSR_SEED : {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
    assign first = 3'(lfsr % 16'd5);
    assign value = (lfsr[7:4] % 4'd9) + 4'd1;
`else
    logic [2:0] ptr;
    always_ff @(posedge clk) begin
        if (rst_n) ptr <= '0;
        else if (tick && found) ptr <= (sel == 3'(NUM_HOLES - 1)) ? '0 : sel + 3'd1;
    end
    assign first = ptr;
    assign value = 4'd1;
`endif

    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_hole
        mole_hole u_hole (
            .clk   (clk),
            .rst_n (rst_n),
            .spawn (spawn_vec[i]),
            .kill  (kill_list[i]),
            .value (value),
            .life  (life),
            .field (moles[FIELD_W*i +: FIELD_W])
        );
        assign empty[i] = moles[FIELD_W*i +: FIELD_W] == '0;
    end
endmodule

// File: tb/tb_mole.sv
// tb_mole: scoreboard bench for mole (round-robin build) with a per-hole lifetime reference model.
module tb_mole;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] life_span = 32'd10;
    logic [31:0] gen_interval = 32'd5;
    logic [4:0]  kill_list = 5'd0;
    logic [19:0] moles;

    int checks = 0;
    int passes = 0;
    logic [19:0] exp_q[$];

    mole dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .life_span    (life_span),
        .gen_interval (gen_interval),
        .kill_list    (kill_list),
        .moles        (moles)
    );

    always #5 clk = ~clk;

    // Reference model: remaining lifetime per hole, spawn timer, round-robin pointer.
    initial begin : model
        int rem[5];
        bit running;
        longint gcnt, g;
        int ptr, t, h;
        bit tk;
        logic [19:0] e;
        running = 0; gcnt = 0; ptr = 0;
        foreach (rem[i]) rem[i] = 0;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                running = 0; gcnt = 0; ptr = 0;
                foreach (rem[i]) rem[i] = 0;
            end else if (!running) begin
                if (start) begin running = 1; gcnt = 0; end
            end else begin
                g  = (gen_interval == 0) ? 1 : longint'(gen_interval);
                tk = gcnt >= g - 1;
                t  = -1;
                if (tk)
                    for (int k = 0; k < 5; k++) begin
                        h = (ptr + k) % 5;
                        if (t < 0 && rem[h] == 0) t = h;
                    end
                gcnt = tk ? 0 : gcnt + 1;
                for (int i = 0; i < 5; i++)
                    if (rem[i] > 0) rem[i] = (kill_list[i] || rem[i] == 1) ? 0 : rem[i] - 1;
                if (t >= 0) begin
                    rem[t] = (life_span == 0) ? 1 : int'(life_span);
                    ptr = (t + 1) % 5;
                end
            end
            e = '0;
            for (int i = 0; i < 5; i++) if (rem[i] > 0) e[4*i +: 4] = 4'd1;
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        logic [19:0] want;
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty: moles=%h, no expected entry", moles);
            end else begin
                want = exp_q.pop_front();
                if (moles !== want) $display("FAIL scoreboard @%0t: moles=%h expected=%h", $time, moles, want);
                else passes++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [19:0] want);
        checks++;
        if (moles !== want) $display("FAIL %s: moles=%h expected=%h", name, moles, want);
        else passes++;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick(2);
        rst_n = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        tick(3);
        rst_n = 1'b0;
        chk("reset_zero", 20'h0);
        tick(10);
        chk("idle_no_start", 20'h0);

        do_reset();
        gen_interval = 50; life_span = 100;
        go();
        tick(49);  chk("t2_before_first", 20'h00000);
        tick(1);   chk("t2_first_spawn", 20'h00001);
        tick(50);  chk("t2_second_spawn", 20'h00011);
        tick(49);  chk("t2_pre_expire", 20'h00011);
        tick(1);   chk("t2_expire_spawn", 20'h00110);

        do_reset();
        gen_interval = 30; life_span = 150;
        go();
        tick(150); chk("t3_full", 20'h11111);
        tick(29);  chk("t3_pre_expire", 20'h11111);
        tick(1);   chk("t3_sixth_skipped", 20'h11110);
        tick(29);  chk("t3_hold", 20'h11110);
        tick(1);   chk("t3_refill", 20'h11101);

        do_reset();
        gen_interval = 10; life_span = 1000;
        go();
        tick(50);  chk("t4_full", 20'h11111);
        kill_list = 5'b01011;
        tick(1);   kill_list = 5'b0;
        chk("t4_kill", 20'h10100);
        kill_list = 5'b00001;
        tick(1);   kill_list = 5'b0;
        chk("t5_kill_empty", 20'h10100);
        tick(8);   chk("t4_respawn", 20'h10101);

        do_reset();
        gen_interval = 4; life_span = 20;
        go();
        tick(23);  chk("t5_full", 20'h11111);
        kill_list = 5'b00001;
        tick(1);   kill_list = 5'b0;
        chk("t5_kill_expire", 20'h11110);
        tick(3);   chk("t5_no_respawn", 20'h11110);
        tick(1);   chk("t5_refill", 20'h11101);

        gen_interval = 3; life_span = 50;
        rst_n = 1'b1;
        tick(1);   chk("t6_reset_mid_run", 20'h0);
        rst_n = 1'b0;
        tick(20);  chk("t6_idle_after_reset", 20'h0);
        go();
        tick(3);   chk("t6_restart", 20'h00001);

        for (int it = 0; it < 6; it++) begin
            do_reset();
            gen_interval = $urandom_range(0, 8);
            life_span = $urandom_range(0, 30);
            go();
            for (int c = 0; c < 300; c++) begin
                kill_list = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
                start = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 49) == 0) gen_interval = $urandom_range(0, 12);
                if ($urandom_range(0, 49) == 0) life_span = $urandom_range(0, 40);
                rst_n = ($urandom_range(0, 199) == 0);
                tick(1);
            end
            kill_list = 5'd0; start = 1'b0; rst_n = 1'b0;
        end

        tick(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
